// File: rtl/sys_seq_pkg.sv
// ============================================================================
// sys_seq_pkg : shared types and helpers for the systolic job sequencer
// Revision    : 1.0
// ============================================================================
`default_nettype none

package sys_seq_pkg;

    localparam int PERF_W = 16;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_COMPUTE = 3'd2,
        S_DRAIN   = 3'd3,
        S_READ    = 3'd4,
        S_DONE    = 3'd5
    } seq_state_t;

    // Number of counter values a phase walks through; READ is stall-extended.
    function automatic int phase_len(input seq_state_t s, input int n);
        case (s)
            S_LOAD, S_READ: phase_len = n;
            S_COMPUTE:      phase_len = 2 * n - 1;
            S_DRAIN:        phase_len = n - 1;
            default:        phase_len = 1;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/sys_seq_counter.sv
// ============================================================================
// sys_seq_counter : phase counter with clear, enable and terminal-count flag
// Revision        : 1.0
// ============================================================================
`default_nettype none

module sys_seq_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic [W-1:0] d_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Saturates at the limit so a phase can never wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != limit_i)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign d_o  = cnt_d;
    assign tc_o = (cnt_q == limit_i);

endmodule

`default_nettype wire

// File: rtl/systolic_seq_ctrl.sv
// ============================================================================
// systolic_seq_ctrl : job sequencer (load / compute / drain / readout) for the
//                     NxN systolic array. SYS_SEQ_PERF_EN builds perf_cycles.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module systolic_seq_ctrl
    import sys_seq_pkg::*;
#(
    parameter  int N  = 4,
    localparam int CW = $clog2(2 * N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              irq_clr,
    output logic              busy,
    output logic              irq,
    output logic              load_en,
    output logic [CW-1:0]     load_row,
    output logic              act_en,
    output logic [CW-1:0]     act_step,
    output logic              flush,
    output logic              res_valid,
    output logic [CW-1:0]     res_row,
    input  logic              res_ready,
    output logic [PERF_W-1:0] perf_cycles
);

    seq_state_t    state_q, state_d;
    logic          cnt_clr, cnt_en, cnt_tc;
    logic [CW-1:0] cnt_d, cnt_limit;
    logic          irq_q, irq_d, irq_set;
    logic          busy_q, load_en_q, act_en_q, flush_q, res_valid_q;
    logic [CW-1:0] load_row_q, act_step_q, res_row_q;

    assign cnt_limit = CW'(phase_len(state_q, N) - 1);

    sys_seq_counter #(.W(CW)) u_phase_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .limit_i (cnt_limit),
        .d_o     (cnt_d),
        .tc_o    (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    state_d = S_LOAD;
                    cnt_clr = 1'b1;
                end
                S_LOAD: if (cnt_tc) begin
                    state_d = S_COMPUTE;
                    cnt_clr = 1'b1;
                end else cnt_en = 1'b1;
                S_COMPUTE: if (cnt_tc) begin
                    state_d = S_DRAIN;
                    cnt_clr = 1'b1;
                end else cnt_en = 1'b1;
                S_DRAIN: if (cnt_tc) begin
                    state_d = S_READ;
                    cnt_clr = 1'b1;
                end else cnt_en = 1'b1;
                S_READ: if (res_ready) begin
                    if (cnt_tc) begin
                        state_d = S_DONE;
                        cnt_clr = 1'b1;
                    end else cnt_en = 1'b1;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    assign irq_set = (state_q == S_DONE) && !abort;
    assign irq_d   = irq_set | (irq_q & ~irq_clr);

    // Outputs are decoded from next state so every port comes from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            irq_q       <= 1'b0;
            busy_q      <= 1'b0;
            load_en_q   <= 1'b0;
            load_row_q  <= '0;
            act_en_q    <= 1'b0;
            act_step_q  <= '0;
            flush_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_row_q   <= '0;
        end else begin
            state_q     <= state_d;
            irq_q       <= irq_d;
            busy_q      <= (state_d != S_IDLE);
            load_en_q   <= (state_d == S_LOAD);
            load_row_q  <= (state_d == S_LOAD) ? cnt_d : '0;
            act_en_q    <= (state_d == S_COMPUTE);
            act_step_q  <= (state_d == S_COMPUTE) ? cnt_d : '0;
            flush_q     <= (state_d == S_DRAIN);
            res_valid_q <= (state_d == S_READ);
            res_row_q   <= (state_d == S_READ) ? cnt_d : '0;
        end
    end

    assign busy      = busy_q;
    assign irq       = irq_q;
    assign load_en   = load_en_q;
    assign load_row  = load_row_q;
    assign act_en    = act_en_q;
    assign act_step  = act_step_q;
    assign flush     = flush_q;
    assign res_valid = res_valid_q;
    assign res_row   = res_row_q;

`ifdef SYS_SEQ_PERF_EN
    logic [PERF_W-1:0] pcnt_q, perf_q;

    // Preloaded to 1 while idle so the latched value counts every busy cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q <= '0;
            perf_q <= '0;
        end else begin
            if (state_q == S_IDLE) begin
                pcnt_q <= PERF_W'(1);
            end else if (pcnt_q != {PERF_W{1'b1}}) begin
                pcnt_q <= pcnt_q + 1'b1;
            end
            if (irq_set) begin
                perf_q <= pcnt_q;
            end
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_systolic_seq_ctrl.sv
// ============================================================================
// tb_systolic_seq_ctrl : scoreboard bench for systolic_seq_ctrl (N=4)
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_systolic_seq_ctrl;

    localparam int N  = 4;
    localparam int CW = $clog2(2 * N);

    logic          clk = 1'b0;
    logic          rst, start, abort, irq_clr, res_ready;
    logic          busy, irq, load_en, act_en, flush, res_valid;
    logic [CW-1:0] load_row, act_step, res_row;
    logic [15:0]   perf_cycles;

    systolic_seq_ctrl #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .irq_clr     (irq_clr),
        .busy        (busy),
        .irq         (irq),
        .load_en     (load_en),
        .load_row    (load_row),
        .act_en      (act_en),
        .act_step    (act_step),
        .flush       (flush),
        .res_valid   (res_valid),
        .res_row     (res_row),
        .res_ready   (res_ready),
        .perf_cycles (perf_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          busy;
        logic          irq;
        logic          load_en;
        logic [CW-1:0] load_row;
        logic          act_en;
        logic [CW-1:0] act_step;
        logic          flush;
        logic          res_valid;
        logic [CW-1:0] res_row;
        logic [15:0]   perf;
    } obs_t;

    obs_t sb[$];
    obs_t idle_exp = '0;
    int   errors = 0;
    int   checks = 0;
    logic model_irq = 1'b0;
    logic [15:0] model_perf = '0;

    function automatic obs_t observed();
        observed = {busy, irq, load_en, load_row, act_en, act_step,
                    flush, res_valid, res_row, perf_cycles};
    endfunction

    // Monitor: one expected observation per cycle while a job is pending,
    // otherwise the quiet idle picture left by the last popped entry.
    always @(negedge clk) begin
        obs_t e, a;
        a = observed();
        if (sb.size() > 0) begin
            e = sb.pop_front();
            idle_exp      = '0;
            idle_exp.irq  = e.irq;
            idle_exp.perf = e.perf;
        end else begin
            e = idle_exp;
        end
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL cycle_obs t=%0t actual=%h expected=%h", $time, a, e);
        end
    end

    function automatic obs_t busy_rec();
        obs_t r = '0;
        r.busy = 1'b1;
        r.irq  = model_irq;
        r.perf = model_perf;
        return r;
    endfunction

    // Entered and left at posedge+1. clr_at: -1 none, -2 with start, -3 on
    // the DONE cycle. abort_at/glitch_at/rst_at: busy-cycle index or -1.
    task automatic run_job(input int st[N], input int abort_at, input int glitch_at,
                           input int clr_at, input int rst_at);
        obs_t recs[$];
        bit   rdy[$];
        obs_t r;
        int   len, clr_idx;
        logic [15:0] pexp;
        start   = 1'b1;
        irq_clr = (clr_at == -2);
        @(posedge clk); #1;
        start   = 1'b0;
        irq_clr = 1'b0;
        if (clr_at == -2) model_irq = 1'b0;

        for (int k = 0; k < N; k++) begin
            r = busy_rec(); r.load_en = 1'b1; r.load_row = CW'(k);
            recs.push_back(r); rdy.push_back($urandom_range(0, 1) != 0);
        end
        for (int k = 0; k < 2 * N - 1; k++) begin
            r = busy_rec(); r.act_en = 1'b1; r.act_step = CW'(k);
            recs.push_back(r); rdy.push_back($urandom_range(0, 1) != 0);
        end
        for (int k = 0; k < N - 1; k++) begin
            r = busy_rec(); r.flush = 1'b1;
            recs.push_back(r); rdy.push_back($urandom_range(0, 1) != 0);
        end
        for (int k = 0; k < N; k++) begin
            for (int s = 0; s <= st[k]; s++) begin
                r = busy_rec(); r.res_valid = 1'b1; r.res_row = CW'(k);
                recs.push_back(r); rdy.push_back(s == st[k]);
            end
        end
        r = busy_rec();
        recs.push_back(r); rdy.push_back($urandom_range(0, 1) != 0);
        len     = recs.size();
        clr_idx = (clr_at == -3) ? len - 1 : -1;
`ifdef SYS_SEQ_PERF_EN
        pexp = 16'(len);
`else
        pexp = 16'd0;
`endif

        if (abort_at >= 0) begin
            for (int i = 0; i <= abort_at; i++) sb.push_back(recs[i]);
            r = '0; r.irq = model_irq; r.perf = model_perf;
            sb.push_back(r);
        end else if (rst_at >= 0) begin
            for (int i = 0; i < rst_at; i++) sb.push_back(recs[i]);
        end else begin
            foreach (recs[i]) sb.push_back(recs[i]);
            r = '0; r.irq = 1'b1; r.perf = pexp;
            sb.push_back(r);
        end

        for (int i = 0; i < len; i++) begin
            res_ready = rdy[i];
            start     = (i == glitch_at);
            abort     = (i == abort_at);
            irq_clr   = (i == clr_idx);
            if (i == rst_at) begin
                rst = 1'b1;
                sb.push_back(obs_t'(0));
                #1;
                checks++;
                if (observed() !== obs_t'(0)) begin
                    errors++;
                    $display("FAIL async_reset actual=%h expected=%h", observed(), obs_t'(0));
                end
                model_irq  = 1'b0;
                model_perf = '0;
                @(posedge clk); #1;
                rst = 1'b0;
                break;
            end
            @(posedge clk); #1;
            if (i == abort_at) break;
        end
        start = 1'b0; abort = 1'b0; irq_clr = 1'b0; res_ready = 1'b1;
        if (abort_at < 0 && rst_at < 0) begin
            model_irq  = 1'b1;
            model_perf = pexp;
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic clear_irq();
        obs_t r;
        irq_clr = 1'b1;
        @(posedge clk); #1;
        irq_clr   = 1'b0;
        model_irq = 1'b0;
        r = '0; r.perf = model_perf;
        sb.push_back(r);
    endtask

    initial begin
        int st[N];
        rst = 1'b1; start = 1'b0; abort = 1'b0; irq_clr = 1'b0; res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle_cycles(2);

        // plain job, then row-2 stall, then start glitch in COMPUTE
        run_job('{0, 0, 0, 0}, -1, -1, -1, -1);     idle_cycles(3);
        run_job('{0, 0, 3, 0}, -1, -1, -1, -1);     idle_cycles(3);
        run_job('{0, 0, 0, 0}, -1, N + 2, -1, -1);  idle_cycles(3);
        // abort in DRAIN with irq cleared beforehand
        clear_irq();                                idle_cycles(2);
        run_job('{0, 0, 0, 0}, 3 * N, -1, -1, -1);  idle_cycles(3);
        // abort in IDLE has no effect
        abort = 1'b1; idle_cycles(1); abort = 1'b0; idle_cycles(2);
        // irq_clr on the DONE exit edge loses to the set
        run_job('{1, 0, 0, 2}, -1, -1, -3, -1);     idle_cycles(3);
        clear_irq();                                idle_cycles(2);
        run_job('{0, 0, 0, 0}, -1, -1, -1, -1);     idle_cycles(2);
        run_job('{0, 1, 0, 0}, -1, -1, -2, -1);     idle_cycles(3);
        // reset in READ, then a clean job
        run_job('{0, 0, 0, 0}, -1, -1, -1, 4 * N - 1); idle_cycles(2);
        run_job('{0, 0, 0, 0}, -1, -1, -1, -1);     idle_cycles(3);

        for (int j = 0; j < 6; j++) begin
            for (int k = 0; k < N; k++) st[k] = $urandom_range(0, 3);
            run_job(st, -1, ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 3 * N)) : -1,
                    -1, -1);
            idle_cycles($urandom_range(1, 4));
            if ($urandom_range(0, 1) != 0) begin
                clear_irq();
                idle_cycles(1);
            end
        end

        idle_cycles(3);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
